// File: rtl/bt_pipe_initiator.sv
// -----------------------------------------------------------------------------
// bt_pipe_initiator
// Host-side emulator for block-throttled pipe endpoints. The write channel
// pushes pattern words in fixed-size blocks into a pipe-in sink; the read
// channel pulls blocks from a pipe-out source and checks every word against
// the same pattern. Both channels run concurrently from one start pulse.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   start             one-cycle run request (ignored while busy or during done)
//   mode              0 = 32-bit LFSR pattern, 1 = 16-bit incrementing counter
//   num_blocks        blocks per channel, captured on an accepted start
//   pi_ready          sink can take a full block
//   pi_blockstrobe    one-cycle pulse ahead of each write block
//   pi_write/pi_data  write strobe and data, valid in the same cycle
//   po_ready          source holds a full block
//   po_blockstrobe    one-cycle pulse ahead of each read block
//   po_read           read strobe
//   po_data           read data, valid exactly one cycle after po_read
//   busy, done        run in progress / one-cycle end-of-run pulse
//   error_count       saturating count of read mismatches
// -----------------------------------------------------------------------------

// One block-throttled channel: handshake FSM, block/word/gap counters and an
// independent pattern generator. All outputs are registered.
module bt_pipe_chan #(
    parameter int          BLOCK_WORDS = 256,
    parameter int          GAP_CYCLES  = 4,
    parameter logic [31:0] SEED        = 32'h0000_0001,
    parameter bit          DRAIN       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_acc,
    input  logic        mode,
    input  logic [15:0] num_blocks,
    input  logic        ready,
    input  logic        fin_ack,
    output logic        blockstrobe,
    output logic        xfer,
    output logic [15:0] word,
    output logic        fin
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_STROBE = 3'd2,
        S_XFER   = 3'd3,
        S_GAP    = 3'd4,
        S_DRAIN  = 3'd5,
        S_FIN    = 3'd6
    } chan_state_e;

    localparam logic [10:0] WORD_LAST = 11'(BLOCK_WORDS - 1);
    localparam logic [7:0]  GAP_LAST  = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit          HAS_GAP   = (GAP_CYCLES > 0);
    // The read channel spends one extra cycle so the last data check lands
    // before it reports FIN.
    localparam chan_state_e LAST_STATE = DRAIN ? S_DRAIN : S_FIN;

    // x^32+x^22+x^2+x+1, Fibonacci form, shift left, feedback into bit 0
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    chan_state_e state_q, state_d;
    logic [15:0] blk_q, blk_d;
    logic [10:0] wcnt_q, wcnt_d;
    logic [7:0]  gcnt_q, gcnt_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        blockstrobe_q;
    logic        xfer_q;
    logic [15:0] word_q;
    logic        adv_s;
    logic [15:0] word_s;

    // Channel state machine and block/word/gap counters
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    blk_d = num_blocks;
                    if (num_blocks != 16'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (ready) begin
                    state_d = S_STROBE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STROBE: begin
                state_d = S_XFER;
                wcnt_d  = 11'd0;
            end
            S_XFER: begin
                // ready is deliberately not looked at while a block is moving
                if (wcnt_q == WORD_LAST) begin
                    blk_d = blk_q - 16'd1;
                    if (HAS_GAP) begin
                        state_d = S_GAP;
                        gcnt_d  = 8'd0;
                    end else if (blk_q != 16'd1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = LAST_STATE;
                    end
                end else begin
                    wcnt_d = wcnt_q + 11'd1;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    if (blk_q != 16'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = LAST_STATE;
                    end
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                if (fin_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pattern generator: reload on start, advance once per transferred word
    always_comb begin
        adv_s = (state_d == S_XFER);
        if (start_acc) begin
            lfsr_d = SEED;
            cnt_d  = 16'd0;
        end else if (adv_s) begin
            if (mode) begin
                lfsr_d = lfsr_q;
                cnt_d  = cnt_q + 16'd1;
            end else begin
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = cnt_q;
            end
        end else begin
            lfsr_d = lfsr_q;
            cnt_d  = cnt_q;
        end
        if (mode) begin
            word_s = cnt_q;
        end else begin
            word_s = lfsr_q[15:0];
        end
    end

    // Channel registers; strobes are decoded from the next state so they
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            blk_q         <= 16'd0;
            wcnt_q        <= 11'd0;
            gcnt_q        <= 8'd0;
            lfsr_q        <= SEED;
            cnt_q         <= 16'd0;
            blockstrobe_q <= 1'b0;
            xfer_q        <= 1'b0;
            word_q        <= 16'd0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            wcnt_q        <= wcnt_d;
            gcnt_q        <= gcnt_d;
            lfsr_q        <= lfsr_d;
            cnt_q         <= cnt_d;
            blockstrobe_q <= (state_d == S_STROBE);
            xfer_q        <= adv_s;
            word_q        <= adv_s ? word_s : 16'd0;
        end
    end

    assign blockstrobe = blockstrobe_q;
    assign xfer        = xfer_q;
    assign word        = word_q;
    assign fin         = (state_q == S_FIN);

endmodule

// Top level: start/busy/done control, the two channels and the read checker.
module bt_pipe_initiator #(
    parameter int          BLOCK_WORDS = 256,
    parameter int          GAP_CYCLES  = 4,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] num_blocks,
    input  logic        pi_ready,
    output logic        pi_blockstrobe,
    output logic        pi_write,
    output logic [15:0] pi_data,
    input  logic        po_ready,
    output logic        po_blockstrobe,
    output logic        po_read,
    input  logic [15:0] po_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] error_count
);

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mode_q, mode_d;
    logic        chk_pend_q, chk_pend_d;
    logic [15:0] chk_exp_q, chk_exp_d;
    logic [15:0] err_q, err_d;
    logic        start_acc_s;
    logic        both_fin_s;
    logic        mismatch_s;
    logic        wr_fin_s;
    logic        rd_fin_s;
    logic [15:0] rd_word_s;

    // Run control and read-data checker
    always_comb begin
        // A start landing on the done cycle is dropped along with busy ones.
        start_acc_s = start && !busy_q && !done_q;
        both_fin_s  = wr_fin_s && rd_fin_s;
        if (start_acc_s) begin
            busy_d = 1'b1;
        end else if (both_fin_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        done_d = both_fin_s;
        if (start_acc_s) begin
            mode_d = mode;
        end else begin
            mode_d = mode_q;
        end
        // Expected word travels one cycle behind po_read to meet the data.
        chk_pend_d = po_read;
        chk_exp_d  = rd_word_s;
        mismatch_s = chk_pend_q && (po_data != chk_exp_q);
        if (start_acc_s) begin
            err_d = 16'd0;
        end else if (mismatch_s && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end else begin
            err_d = err_q;
        end
    end

    // Control and checker registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= 1'b0;
            chk_pend_q <= 1'b0;
            chk_exp_q  <= 16'd0;
            err_q      <= 16'd0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            chk_pend_q <= chk_pend_d;
            chk_exp_q  <= chk_exp_d;
            err_q      <= err_d;
        end
    end

    bt_pipe_chan #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .GAP_CYCLES  (GAP_CYCLES),
        .SEED        (SEED),
        .DRAIN       (1'b0)
    ) u_wr (
        .clk         (clk),
        .reset       (reset),
        .start_acc   (start_acc_s),
        .mode        (mode_q),
        .num_blocks  (num_blocks),
        .ready       (pi_ready),
        .fin_ack     (both_fin_s),
        .blockstrobe (pi_blockstrobe),
        .xfer        (pi_write),
        .word        (pi_data),
        .fin         (wr_fin_s)
    );

    bt_pipe_chan #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .GAP_CYCLES  (GAP_CYCLES),
        .SEED        (SEED),
        .DRAIN       (1'b1)
    ) u_rd (
        .clk         (clk),
        .reset       (reset),
        .start_acc   (start_acc_s),
        .mode        (mode_q),
        .num_blocks  (num_blocks),
        .ready       (po_ready),
        .fin_ack     (both_fin_s),
        .blockstrobe (po_blockstrobe),
        .xfer        (po_read),
        .word        (rd_word_s),
        .fin         (rd_fin_s)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign error_count = err_q;

endmodule

// File: doc/bt_pipe_initiator.md
Name: bt_pipe_initiator

Overview:
- Synthesizable host-side emulator for block-throttled pipe endpoints. It is the initiator for the pipe_in_check and pipe_out_check fabric responders.
- Write channel: pushes pattern data in fixed-size blocks into a pipe-in sink. Read channel: pulls blocks from a pipe-out source and checks them against the same pattern.
- Used for on-chip loopback and benchmarking of pipe logic without the USB host. Sits on ti_clk beside the pipe test blocks.

Parameters:
- BLOCK_WORDS, 256, 16-bit words per block; range 2..1024.
- GAP_CYCLES, 4, idle cycles after each block before the next ready sample; range 0..255.
- SEED, 32'h0000_0001, LFSR reset/start value; must be nonzero.

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a run; ignored while busy=1
- mode  in  1  0 = 32-bit LFSR pattern, 1 = 16-bit incrementing counter
- num_blocks  in  16  blocks per channel per run; sampled on accepted start
- pi_ready  in  1  sink can accept one full block
- pi_blockstrobe  out  1  one-cycle pulse before each write block
- pi_write  out  1  write strobe, data valid same cycle
- pi_data  out  16  write data
- po_ready  in  1  source holds one full block
- po_blockstrobe  out  1  one-cycle pulse before each read block
- po_read  out  1  read strobe
- po_data  in  16  read data, valid exactly 1 cycle after po_read
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- error_count  out  16  read mismatches, saturating

Behaviour:
- Reset values: all outputs 0; both pattern generators = SEED (LFSR mode) or 0x0000 (counter mode); FSMs in IDLE. Reset mid-run aborts immediately with no further strobes.
- Pattern: LFSR polynomial x^32+x^22+x^2+x+1, Fibonacci form, shifting left, feedback into bit 0.
  - Word = lfsr[15:0]. The generator advances once per transferred word.
  - Counter mode: words 0x0000, 0x0001, ..., wrapping at 0xFFFF to 0x0000.
  - Write and read channels each own an independent generator; both reload on accepted start.
- Accepted start: busy goes 1 the next cycle; error_count clears to 0; block counters load num_blocks.
- Write FSM:
  - IDLE -> WAIT_RDY on accepted start if num_blocks != 0.
  - WAIT_RDY: when pi_ready=1, go to STROBE.
  - STROBE: pi_blockstrobe=1 for exactly 1 cycle.
  - XFER: pi_write=1 for exactly BLOCK_WORDS consecutive cycles. pi_ready is ignored during XFER.
  - GAP: GAP_CYCLES idle cycles. Then WAIT_RDY if blocks remain, else FIN.
- Read FSM: same state sequence on po_ready, po_blockstrobe and po_read.
  - Check pipeline: po_data is sampled one cycle after each po_read and compared with the expected word.
  - Each mismatch adds 1 to error_count; it saturates at 0xFFFF.
  - The read FSM reaches FIN only after the final check cycle has completed.
- Completion:
  - When both FSMs are in FIN, done pulses for 1 cycle, busy drops in the same cycle, and both FSMs return to IDLE.
  - num_blocks = 0: both FSMs go straight to FIN; done pulses 2 cycles after start with no strobes.
- Timing and concurrency:
  - The two channels run concurrently and independently; there is no ordering between them.
  - A start that coincides with done is ignored.
  - Minimum latency from pi_ready=1 (sampled in WAIT_RDY) to the first pi_write is 2 cycles (STROBE, then XFER).
- error_count holds its value after done until the next accepted start or reset.

Test Plan:
- Counter mode, num_blocks=1, BLOCK_WORDS=4, GAP=0, pi_ready tied 1 -> pi_blockstrobe 1 cycle, then pi_write for 4 cycles carrying 0x0000,0x0001,0x0002,0x0003; done pulses once; busy=0 afterwards.
- Loopback of the read side to a counter-mode source model, num_blocks=3, BLOCK_WORDS=256 -> exactly 768 po_read cycles, 3 po_blockstrobe pulses, error_count=0.
- Same as above with the source corrupting word 10 of block 2 (bit 0 flipped) -> error_count=1; error_count=0 again after the next start.
- LFSR mode, pi_ready held 0 for 50 cycles then 1 -> no pi_write while ready is low; the first 8 words match the reference LFSR model from SEED=1 (first word 0x0001).
- Reset asserted mid-XFER in word 100 -> pi_write and busy are 0 within the same cycle (async); the next start restarts the pattern at 0x0001 (LFSR) or 0x0000 (counter).
- num_blocks=0 start -> done exactly 2 cycles later, no strobes; a start pulsed while busy is ignored (block count unchanged).
